// File: rtl/mem_read_serializer.sv
// Read-side serializer for the latch-based word memory: strobes rd_en, captures the
// addressed word and replays it in parallel and as an LSB-first serial stream.
module mem_read_serializer #(
  parameter int WORD_WIDTH = 5,
  parameter int NUM_WORDS  = 4,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            rd_req,
  input  logic [ADDR_WIDTH-1:0]           rd_addr,
  input  logic [NUM_WORDS*WORD_WIDTH-1:0] mem_data,
  output logic                            rd_en,
  output logic                            busy,
  output logic [WORD_WIDTH-1:0]           par_data,
  output logic                            par_valid,
  output logic                            ser_out,
  output logic                            ser_valid,
  output logic                            done,
  output logic                            addr_err
);

  localparam int CNT_W = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_SHIFT   = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  // Out-of-range addresses read back as all zeros.
  function automatic logic [WORD_WIDTH-1:0] select_word(
    input logic [ADDR_WIDTH-1:0]           addr,
    input logic [NUM_WORDS*WORD_WIDTH-1:0] data
  );
    logic [WORD_WIDTH-1:0] w;
    w = '0;
    for (int n = 0; n < NUM_WORDS; n++) begin
      if (int'(addr) == n) begin
        w = data[n*WORD_WIDTH +: WORD_WIDTH];
      end else begin
        w = w;
      end
    end
    return w;
  endfunction

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [WORD_WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  rd_en_q, rd_en_d;
  logic                  busy_q, busy_d;
  logic [WORD_WIDTH-1:0] par_data_q, par_data_d;
  logic                  par_valid_q, par_valid_d;
  logic                  ser_out_q, ser_out_d;
  logic                  ser_valid_q, ser_valid_d;
  logic                  done_q, done_d;
  logic                  addr_err_q, addr_err_d;

  logic [WORD_WIDTH-1:0] capture_word_s;
  logic [WORD_WIDTH-1:0] shift_next_s;

  assign capture_word_s = select_word(addr_q, mem_data);
  assign shift_next_s   = shift_q >> 1'b1;

  // Next-state and next-output computation for the read sequencer.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    rd_en_d     = rd_en_q;
    busy_d      = busy_q;
    par_data_d  = par_data_q;
    par_valid_d = par_valid_q;
    ser_out_d   = ser_out_q;
    ser_valid_d = ser_valid_q;
    done_d      = done_q;
    addr_err_d  = addr_err_q;

    case (state_q)
      S_IDLE: begin
        if (rd_req) begin
          addr_d     = rd_addr;
          rd_en_d    = 1'b1;
          busy_d     = 1'b1;
          addr_err_d = (int'(rd_addr) >= NUM_WORDS);
          state_d    = S_CAPTURE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CAPTURE: begin
        rd_en_d     = 1'b0;
        par_data_d  = capture_word_s;
        shift_d     = capture_word_s;
        par_valid_d = 1'b1;
        ser_out_d   = capture_word_s[0];
        ser_valid_d = 1'b1;
        cnt_d       = '0;
        state_d     = S_SHIFT;
      end
      S_SHIFT: begin
        // The last bit has been on ser_out for one cycle when cnt reaches WORD_WIDTH-1.
        if (cnt_q == CNT_W'(WORD_WIDTH - 1)) begin
          ser_valid_d = 1'b0;
          ser_out_d   = 1'b0;
          done_d      = 1'b1;
          state_d     = S_DONE;
        end else begin
          shift_d   = shift_next_s;
          cnt_d     = cnt_q + CNT_W'(1);
          ser_out_d = shift_next_s[0];
        end
      end
      S_DONE: begin
        done_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        rd_en_d     = 1'b0;
        busy_d      = 1'b0;
        ser_out_d   = 1'b0;
        ser_valid_d = 1'b0;
        done_d      = 1'b0;
        state_d     = S_IDLE;
      end
    endcase
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      shift_q     <= '0;
      cnt_q       <= '0;
      rd_en_q     <= 1'b0;
      busy_q      <= 1'b0;
      par_data_q  <= '0;
      par_valid_q <= 1'b0;
      ser_out_q   <= 1'b0;
      ser_valid_q <= 1'b0;
      done_q      <= 1'b0;
      addr_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      rd_en_q     <= rd_en_d;
      busy_q      <= busy_d;
      par_data_q  <= par_data_d;
      par_valid_q <= par_valid_d;
      ser_out_q   <= ser_out_d;
      ser_valid_q <= ser_valid_d;
      done_q      <= done_d;
      addr_err_q  <= addr_err_d;
    end
  end

  assign rd_en     = rd_en_q;
  assign busy      = busy_q;
  assign par_data  = par_data_q;
  assign par_valid = par_valid_q;
  assign ser_out   = ser_out_q;
  assign ser_valid = ser_valid_q;
  assign done      = done_q;
  assign addr_err  = addr_err_q;

endmodule
